fetch_unit: RTL

//   Instruction fetch stage of the RISC-V core. Owns the program counter, issues

---
 rtl/fetch_unit.sv | 127 ++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one outstanding word read at a time
// and presents {pc, instr} to decode through a valid/ready output register.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        out_ready_i,
  output logic        out_valid_o,
  output logic [31:0] out_pc_o,
  output logic [31:0] out_instr_o
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] hold_q, hold_d;
  logic        kill_q, kill_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic        load;
  logic [31:0] load_instr;
  logic [31:0] pc_inc;

  assign pc_inc = pc_q + 32'd4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      hold_q      <= 32'h0;
      kill_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_pc_q    <= 32'h0;
      out_instr_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      hold_q      <= hold_d;
      kill_q      <= kill_d;
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      out_instr_q <= out_instr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    hold_d     = hold_q;
    kill_d     = kill_q;
    load       = 1'b0;
    load_instr = imem_rdata_i;

    case (state_q)
      S_REQ: begin
        // A grant in the same cycle as a redirect fetches a stale address.
        if (imem_gnt_i) begin
          state_d = S_WAIT;
          kill_d  = redirect_i;
        end
      end
      S_WAIT: begin
        if (imem_rvalid_i) begin
          state_d = S_REQ;
          kill_d  = 1'b0;
          if (!kill_q && !redirect_i) begin
            if (!out_valid_q || out_ready_i) begin
              load = 1'b1;
              pc_d = pc_inc;
            end else begin
              state_d = S_HOLD;
              hold_d  = imem_rdata_i;
            end
          end
        end else if (redirect_i) begin
          kill_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect_i) begin
          state_d = S_REQ;
          hold_d  = 32'h0;
        end else if (out_ready_i) begin
          load       = 1'b1;
          load_instr = hold_q;
          pc_d       = pc_inc;
          state_d    = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase

    if (redirect_i) pc_d = {redirect_pc_i[31:2], 2'b00};
  end

  always_comb begin
    out_pc_d    = out_pc_q;
    out_instr_d = out_instr_q;
    out_valid_d = out_valid_q;
    if (redirect_i) begin
      out_valid_d = 1'b0;
    end else if (load) begin
      out_valid_d = 1'b1;
      out_pc_d    = pc_q;
      out_instr_d = load_instr;
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  assign imem_req_o  = rst_n && (state_q == S_REQ);
  assign imem_addr_o = pc_q;
  assign out_valid_o = out_valid_q;
  assign out_pc_o    = out_pc_q;
  assign out_instr_o = out_instr_q;

endmodule
